// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fib_pkg
//  Description : Shared definitions for the Fibonacci generator / checker
//                pair: checker state encoding and the two seed terms.
//  Revision    : 1.0 - initial release
// ============================================================================
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEEN_F0 = 2'd1,
        RUN     = 2'd2,
        FAIL    = 2'd3
    } fib_chk_state_t;

    // Seed terms, shared with the generator so both sides agree on F0/F1.
    localparam int FIB_F0 = 1;
    localparam int FIB_F1 = 1;

endpackage
`default_nettype wire

// File: rtl/fib_stream_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : fib_stream_checker_if
//  Description : Term stream from the generator plus the checker's status.
//                  in_valid/in_data : term handed over this cycle
//                  clear            : one-cycle synchronous flush
//                  locked/err/err_index/expected/term_count/overflow : status
//                master = stream source / status observer, slave = checker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fib_stream_checker_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) ();

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  clear;
    logic                  locked;
    logic                  err;
    logic [CNT_WIDTH-1:0]  err_index;
    logic [DATA_WIDTH-1:0] expected;
    logic [CNT_WIDTH-1:0]  term_count;
    logic                  overflow;

    modport master (
        output in_valid, in_data, clear,
        input  locked, err, err_index, expected, term_count, overflow
    );

    modport slave (
        input  in_valid, in_data, clear,
        output locked, err, err_index, expected, term_count, overflow
    );

endinterface
`default_nettype wire

// File: rtl/fib_next_term.sv
`default_nettype none
// ============================================================================
//  Module      : fib_next_term
//  Description : Combinational next-term predictor: {carry, sum} = prev1 + prev2.
//                  prev1, prev2 : last two accepted terms
//                  sum          : predicted term modulo 2^DATA_WIDTH
//                  carry        : set when the true sum wraps
//  Revision    : 1.0 - initial release
// ============================================================================
module fib_next_term #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic [DATA_WIDTH-1:0] prev1,
    input  wire logic [DATA_WIDTH-1:0] prev2,
    output logic      [DATA_WIDTH-1:0] sum,
    output logic                       carry
);

    assign {carry, sum} = {1'b0, prev1} + {1'b0, prev2};

endmodule
`default_nettype wire

// File: rtl/fib_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module      : fib_stream_checker
//  Description : Monitors the Fibonacci term stream, predicts each term and
//                latches the first mismatch until clear/reset.
//                  clk, resetn : clock, synchronous active-low reset
//                  bus (slave) : in_valid/in_data/clear in; locked, err,
//                                err_index, expected, term_count, overflow out
//                All status is registered (visible the cycle after sampling).
//  Revision    : 1.0 - initial release
// ============================================================================
module fib_stream_checker
    import fib_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic           clk,
    input  wire logic           resetn,
    fib_stream_checker_if.slave bus
);

    localparam logic [DATA_WIDTH-1:0] c_f0 = DATA_WIDTH'(FIB_F0);
    localparam logic [DATA_WIDTH-1:0] c_f1 = DATA_WIDTH'(FIB_F1);

    fib_chk_state_t        r_state,     w_state_nxt;
    logic [DATA_WIDTH-1:0] r_prev1,     w_prev1_nxt;
    logic [DATA_WIDTH-1:0] r_prev2,     w_prev2_nxt;
    logic [DATA_WIDTH-1:0] r_expected,  w_expected_nxt;
    logic [CNT_WIDTH-1:0]  r_count,     w_count_nxt;
    logic [CNT_WIDTH-1:0]  r_err_index, w_err_index_nxt;
    logic                  r_overflow,  w_overflow_nxt;

    logic [DATA_WIDTH-1:0] w_sum;
    logic                  w_carry;

    fib_next_term #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_next_term (
        .prev1 (r_prev1),
        .prev2 (r_prev2),
        .sum   (w_sum),
        .carry (w_carry)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_prev1     <= '0;
            r_prev2     <= '0;
            r_expected  <= c_f0;
            r_count     <= '0;
            r_err_index <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev1     <= w_prev1_nxt;
            r_prev2     <= w_prev2_nxt;
            r_expected  <= w_expected_nxt;
            r_count     <= w_count_nxt;
            r_err_index <= w_err_index_nxt;
            r_overflow  <= w_overflow_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_prev1_nxt     = r_prev1;
        w_prev2_nxt     = r_prev2;
        w_expected_nxt  = r_expected;
        w_count_nxt     = r_count;
        w_err_index_nxt = r_err_index;
        w_overflow_nxt  = r_overflow;

        if (bus.clear) begin
            // Same image as reset; a term presented alongside clear is dropped.
            w_state_nxt     = IDLE;
            w_prev1_nxt     = '0;
            w_prev2_nxt     = '0;
            w_expected_nxt  = c_f0;
            w_count_nxt     = '0;
            w_err_index_nxt = '0;
            w_overflow_nxt  = 1'b0;
        end else if (bus.in_valid) begin
            case (r_state)
                IDLE: begin
                    if (bus.in_data == c_f0) begin
                        w_state_nxt    = SEEN_F0;
                        w_prev1_nxt    = c_f0;
                        w_count_nxt    = CNT_WIDTH'(1);
                        w_expected_nxt = c_f1;
                    end else begin
                        w_state_nxt     = FAIL;
                        w_err_index_nxt = '0;
                        w_expected_nxt  = c_f0;
                    end
                end
                SEEN_F0: begin
                    if (bus.in_data == c_f1) begin
                        w_state_nxt    = RUN;
                        w_prev2_nxt    = c_f0;
                        w_prev1_nxt    = c_f1;
                        w_count_nxt    = CNT_WIDTH'(2);
                        w_expected_nxt = c_f0 + c_f1;
                    end else begin
                        w_state_nxt     = FAIL;
                        w_err_index_nxt = CNT_WIDTH'(1);
                        w_expected_nxt  = c_f1;
                    end
                end
                RUN: begin
                    // Compare modulo 2^DATA_WIDTH; a wrap is only noted in overflow.
                    if (bus.in_data == w_sum) begin
                        w_prev2_nxt    = r_prev1;
                        w_prev1_nxt    = bus.in_data;
                        w_count_nxt    = (r_count == '1) ? r_count : r_count + 1'b1;
                        w_expected_nxt = bus.in_data + r_prev1;
                        w_overflow_nxt = r_overflow | w_carry;
                    end else begin
                        // count is already the 0-based index of this term.
                        w_state_nxt     = FAIL;
                        w_err_index_nxt = r_count;
                        w_expected_nxt  = w_sum;
                    end
                end
                default: begin
                    // FAIL holds everything until clear or reset.
                end
            endcase
        end
    end

    assign bus.locked     = (r_state == RUN);
    assign bus.err        = (r_state == FAIL);
    assign bus.err_index  = r_err_index;
    assign bus.expected   = r_expected;
    assign bus.term_count = r_count;
    assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire
